// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared state encodings, mode constants and width defaults for the RAM block mover
package ram_ctrl_pkg;
    localparam int AW_DEF = 6;
    localparam int DW_DEF = 16;
    localparam int LW_DEF = 7;
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        FIN  = 2'b11
    } state_t;
endpackage

// File: rtl/ram64_block_mover_if.sv
// ram64_block_mover_if: pin bundle between the block mover (master) and one ram64 (slave)
interface ram64_block_mover_if #(
    parameter int AW = ram_ctrl_pkg::AW_DEF,
    parameter int DW = ram_ctrl_pkg::DW_DEF
);
    logic          m_w;
    logic          m_r;
    logic          m_en;
    logic [AW-1:0] m_add;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_dout;
    modport master (output m_w, m_r, m_en, m_add, m_din, input m_dout);
    modport slave (input m_w, m_r, m_en, m_add, m_din, output m_dout);
endinterface

// File: rtl/ram64_addr_gen.sv
// ram64_addr_gen: block index/count tracker with memmove direction choice; addresses are for the next cycle
module ram64_addr_gen #(
    parameter int AW = ram_ctrl_pkg::AW_DEF,
    parameter int LW = ram_ctrl_pkg::LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic          copy,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    output logic [AW-1:0] src_nxt,
    output logic [AW-1:0] dst_nxt,
    output logic          last
);
    logic [AW-1:0] src_q, src_d, dst_q, dst_d, idx_q, idx_d, off;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          desc_q, desc_d;

    // Descend only when the destination starts inside the source block, so no source word is overwritten before it is read
    always_comb begin
        off     = dst - src;
        src_d   = load ? src : src_q;
        dst_d   = load ? dst : dst_q;
        desc_d  = load ? (copy && off != '0 && LW'(off) < len) : desc_q;
        idx_d   = load ? (desc_d ? AW'(len - LW'(1)) : '0)
                : step ? (desc_q ? idx_q - AW'(1) : idx_q + AW'(1)) : idx_q;
        cnt_d   = load ? len : step ? cnt_q - LW'(1) : cnt_q;
        src_nxt = src_d + idx_d;
        dst_nxt = dst_d + idx_d;
        last    = cnt_q == LW'(1);
    end

    // Index, count and latched bases
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            desc_q <= 1'b0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            desc_q <= desc_d;
        end
    end
endmodule

// File: rtl/ram64_block_mover.sv
// ram64_block_mover: sequences a ram64 for memmove-style block copy and pattern fill
module ram64_block_mover
    import ram_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] pat,
    output logic          busy,
    output logic          done,
    output logic          err,
    ram64_block_mover_if.master ram
);
    state_t        state_q, state_d;
    logic          mode_q, mode_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          m_w_q, m_w_d, m_r_q, m_r_d, m_en_q, m_en_d;
    logic [AW-1:0] m_add_q, m_add_d, src_nxt, dst_nxt;
    logic [DW-1:0] pat_q, pat_d, data_q, data_d, m_din_q, m_din_d;
    logic          accept, zero, bad, load, last;

    ram64_addr_gen #(.AW(AW), .LW(LW)) u_addr (
        .clk(clk), .rst(rst), .load(load), .step(state_q == WR), .copy(mode == MODE_COPY),
        .src(src), .dst(dst), .len(len), .src_nxt(src_nxt), .dst_nxt(dst_nxt), .last(last)
    );

    // Next state plus pin values for the coming cycle, so every RAM pin leaves a flop
    always_comb begin
        accept  = (state_q == IDLE) && start;
        zero    = len == '0;
        bad     = len > LW'(2 ** AW);
        load    = accept && !zero && !bad;
        mode_d  = accept ? mode : mode_q;
        pat_d   = accept ? pat : pat_q;
        data_d  = (state_q == RD) ? ram.m_dout : data_q;
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (zero || bad) ? FIN : (mode == MODE_FILL) ? WR : RD;
            RD:   state_d = WR;
            WR:   state_d = last ? FIN : (mode_q == MODE_FILL) ? WR : RD;
            FIN:  state_d = IDLE;
        endcase
        err_d   = accept && bad;
        done_d  = state_d == FIN;
        m_r_d   = state_d == RD;
        m_w_d   = state_d == WR;
        m_en_d  = m_r_d || m_w_d;
        busy_d  = m_en_d;
        m_add_d = m_r_d ? src_nxt : m_w_d ? dst_nxt : m_add_q;
        m_din_d = m_w_d ? ((mode_d == MODE_FILL) ? pat_d : data_d) : m_din_q;
    end

    // State, latched command and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_COPY;
            pat_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            m_w_q   <= 1'b0;
            m_r_q   <= 1'b0;
            m_en_q  <= 1'b0;
            m_add_q <= '0;
            m_din_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            m_w_q   <= m_w_d;
            m_r_q   <= m_r_d;
            m_en_q  <= m_en_d;
            m_add_q <= m_add_d;
            m_din_q <= m_din_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ram.m_w   = m_w_q;
    assign ram.m_r   = m_r_q;
    assign ram.m_en  = m_en_q;
    assign ram.m_add = m_add_q;
    assign ram.m_din = m_din_q;
endmodule

// File: doc/ram64_block_mover.md
Name: ram64_block_mover

Overview:
- Initiator-side controller that drives the 64x16 word RAM's w/r/en/add/d_in pins and samples its d_out.
- Performs block copy with memmove semantics, so overlapping regions copy correctly, and block fill with a 16-bit pattern.
- Sits between a command source (start/src/dst/len) and one ram64 instance.
- Replaces hand-sequenced RAM stimulus in higher-level datapaths.

Parameters:
- AW, 6, RAM address width; RAM depth is 2**AW = 64.
- DW, 16, RAM data width.
- LW, 7, length field width (AW+1), so 64 is representable.

Ports:
- clk  in  1  rising-edge clock shared with the RAM.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src  in  AW  copy source base address (ignored in fill).
- dst  in  AW  destination base address.
- len  in  LW  word count; legal 1..64; 0 = no-op.
- pat  in  DW  fill pattern (ignored in copy).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done when len > 64.
- m_w  out  1  RAM w.
- m_r  out  1  RAM r.
- m_en  out  1  RAM en.
- m_add  out  AW  RAM add.
- m_din  out  DW  RAM d_in.
- m_dout  in  DW  RAM d_out; may be z when m_r is 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - busy, done, err, m_w, m_r, m_en all 0; m_add=0; m_din=0; internal counter and data register cleared.
  - A reset mid-operation aborts immediately. The RAM strobes drop at that edge. Words already written stay written; no further writes occur.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - On start=1, latch mode/src/dst/len/pat.
  - If len==0 or len>64: go to FIN, with err=1 only for len>64. No RAM access.
  - Otherwise: copy goes to RD, fill goes to WR. Count register loaded with len.
- Copy direction:
  - Compute off = (dst - src) mod 64.
  - If 0 < off < len, descend: the first index is len-1 and it decrements.
  - Otherwise ascend: the first index is 0 and it increments.
  - src == dst still performs the full copy, ascending.
- RD cycle:
  - m_en=1, m_r=1, m_w=0, m_add=(src+idx) mod 64.
  - The RAM read is combinational, so m_dout is captured into the data register at the closing edge.
  - Next state is WR.
- WR cycle:
  - m_en=1, m_w=1, m_r=0, m_add=(dst+idx) mod 64.
  - m_din is the data register for copy, or pat for fill.
  - The RAM writes at the closing edge.
  - Decrement count and step idx.
  - If count becomes 0, go to FIN. Otherwise copy returns to RD and fill stays in WR.
- FIN: done=1 for one cycle, err as set, busy=0, strobes 0, then IDLE.
- Latency:
  - Copy: accepted start → done = 2*len+1 cycles.
  - Fill: len+1 cycles.
  - Illegal len / no-op: 1 cycle.
- Address arithmetic is modulo 64; a block crossing 63→0 wraps silently and is legal.
- m_r and m_w are never both 1. m_en=0 in IDLE and FIN.
- m_add and m_din are registered outputs: no glitches, and they hold their last values when idle.
- start while busy is ignored. Command inputs may change freely after acceptance.
- start in the same cycle as FIN is ignored; a start is accepted only from IDLE.

Decomposition:
- Shared package ram_ctrl_pkg:
  - State encodings (IDLE=2'b00, RD=2'b01, WR=2'b10, FIN=2'b11).
  - Mode constants MODE_COPY=0, MODE_FILL=1.
  - AW/DW/LW defaults.
- One natural sub-module, ram64_addr_gen:
  - Holds idx and count.
  - Performs the overlap/direction decision at load.
  - Produces the src and dst addresses mod 64 and a last flag.
- FSM and output registers live in the top module.

Test Plan:
- Reset then idle → busy=0, done=0, err=0, m_en=0, m_w=0, m_r=0, m_add=0, m_din=0; hold rst 3 cycles with start=1 → no RAM strobes.
- Preload RAM[0..3]=16'h1111,2222,3333,4444; copy src=0, dst=8, len=4 → ascending RD/WR alternation, done 9 cycles after start; RAM[8..11] equal preload, RAM[0..3] unchanged.
- Preload RAM[10..13]=A,B,C,D; copy src=10, dst=11, len=4 → descending order (idx 3..0); RAM[11..14]=A,B,C,D and RAM[10]=A. Repeat with dst=9 → ascending; RAM[9..12]=A,B,C,D.
- Fill dst=62, len=4, pat=16'hBEEF → writes to 62, 63, 0, 1; done 5 cycles after start; RAM[2] untouched.
- len=0 → done after 1 cycle, err=0, no strobes. len=65 → done+err after 1 cycle, no strobes.
- Reset mid-copy (len=8, after 3 WR cycles) → strobes 0 next edge; exactly 3 destination words written. Second start pulsed while busy → ignored, single done.
